// File: rtl/arm_eim_bus_master_if.sv
// Command/response port and CS5 bus pins of the EIM bus master, bundled
// so the master and whatever sits on the far side share one definition.
interface arm_eim_bus_master_if #(
  parameter int AW = 24,
  parameter int DW = 32
);
  // command / response side
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_rw;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [3:0]    cmd_be_n;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  // asynchronous bus side
  logic [AW-1:0] bus_a;
  logic [3:0]    bus_be_b;
  logic          bus_cs_b;
  logic          bus_as;
  logic          bus_rs_b;
  logic          bus_ws_b;
  logic [DW-1:0] bus_d_out;
  logic          bus_d_oe;
  logic [DW-1:0] bus_d_in;
  logic          bus_dtack_b;

  modport master (
    input  cmd_valid, cmd_rw, cmd_addr, cmd_wdata, cmd_be_n, bus_d_in, bus_dtack_b,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output bus_a, bus_be_b, bus_cs_b, bus_as, bus_rs_b, bus_ws_b, bus_d_out, bus_d_oe
  );

  modport slave (
    output cmd_valid, cmd_rw, cmd_addr, cmd_wdata, cmd_be_n, bus_d_in, bus_dtack_b,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  bus_a, bus_be_b, bus_cs_b, bus_as, bus_rs_b, bus_ws_b, bus_d_out, bus_d_oe
  );
endinterface

// File: rtl/arm_eim_bus_master.sv
// ARM CS5 asynchronous bus initiator. Each accepted command becomes one
// bus cycle: SETUP (CS low, AS pulse) -> STROBE (RS_B or WS_B low) ->
// optional WAIT_ACK (DTACK extension with timeout) -> HOLD -> one-cycle
// RESP that releases the bus and pulses rsp_valid.
module arm_eim_bus_master #(
  parameter int AW        = 24,
  parameter int DW        = 32,
  parameter int SETUP     = 2,
  parameter int STROBE    = 4,
  parameter int HOLD      = 2,
  parameter int USE_DTACK = 0,
  parameter int TIMEOUT   = 255
) (
  input logic                    clk,
  input logic                    rst_n,
  arm_eim_bus_master_if.master   bus
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SETUP    = 3'd1;
  localparam logic [2:0] ST_STROBE   = 3'd2;
  localparam logic [2:0] ST_WAIT_ACK = 3'd3;
  localparam logic [2:0] ST_HOLD     = 3'd4;
  localparam logic [2:0] ST_RESP     = 3'd5;

  // One shared phase counter; it must reach the longest phase length minus one.
  localparam int MAX_SS  = (SETUP > STROBE) ? SETUP : STROBE;
  localparam int MAX_SH  = (MAX_SS > HOLD) ? MAX_SS : HOLD;
  localparam int CNT_MAX = (MAX_SH > TIMEOUT) ? MAX_SH : TIMEOUT;
  localparam int CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

  localparam logic [CW-1:0] SETUP_LAST   = CW'(SETUP - 1);
  localparam logic [CW-1:0] STROBE_LAST  = CW'(STROBE - 1);
  localparam logic [CW-1:0] HOLD_LAST    = CW'(HOLD - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT - 1);

  logic [2:0]    state_reg;
  logic [CW-1:0] cnt_reg;
  logic          rw_reg;
  logic [DW-1:0] rdata_cap_reg;
  logic          err_cap_reg;
  logic          dtack_s1_reg;
  logic          dtack_s2_reg;

  logic [AW-1:0] a_reg;
  logic [3:0]    be_b_reg;
  logic          cs_b_reg;
  logic          as_reg;
  logic          rs_b_reg;
  logic          ws_b_reg;
  logic [DW-1:0] d_out_reg;
  logic          d_oe_reg;
  logic          rsp_valid_reg;
  logic [DW-1:0] rsp_rdata_reg;
  logic          rsp_err_reg;

  assign bus.cmd_ready = (state_reg == ST_IDLE);
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_rdata = rsp_rdata_reg;
  assign bus.rsp_err   = rsp_err_reg;
  assign bus.bus_a     = a_reg;
  assign bus.bus_be_b  = be_b_reg;
  assign bus.bus_cs_b  = cs_b_reg;
  assign bus.bus_as    = as_reg;
  assign bus.bus_rs_b  = rs_b_reg;
  assign bus.bus_ws_b  = ws_b_reg;
  assign bus.bus_d_out = d_out_reg;
  assign bus.bus_d_oe  = d_oe_reg;

  // Two-flop synchroniser for the asynchronous DTACK input (idles high).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dtack_s1_reg <= 1'b1;
      dtack_s2_reg <= 1'b1;
    end else begin
      dtack_s1_reg <= bus.bus_dtack_b;
      dtack_s2_reg <= dtack_s1_reg;
    end
  end

  // Bus-cycle sequencer; every bus and response pin comes straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      rw_reg        <= 1'b0;
      rdata_cap_reg <= '0;
      err_cap_reg   <= 1'b0;
      a_reg         <= '0;
      be_b_reg      <= 4'hF;
      cs_b_reg      <= 1'b1;
      as_reg        <= 1'b0;
      rs_b_reg      <= 1'b1;
      ws_b_reg      <= 1'b1;
      d_out_reg     <= '0;
      d_oe_reg      <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
    end else begin
      rsp_valid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            // Latch the command and open the cycle: CS low, AS high for one cycle.
            rw_reg        <= bus.cmd_rw;
            a_reg         <= bus.cmd_addr;
            be_b_reg      <= bus.cmd_be_n;
            d_out_reg     <= bus.cmd_rw ? '0 : bus.cmd_wdata;
            d_oe_reg      <= ~bus.cmd_rw;
            cs_b_reg      <= 1'b0;
            as_reg        <= 1'b1;
            rdata_cap_reg <= '0;
            err_cap_reg   <= 1'b0;
            cnt_reg       <= '0;
            state_reg     <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          as_reg <= 1'b0;
          if (cnt_reg == SETUP_LAST) begin
            cnt_reg   <= '0;
            rs_b_reg  <= ~rw_reg;
            ws_b_reg  <= rw_reg;
            state_reg <= ST_STROBE;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end

        ST_STROBE: begin
          if (cnt_reg == STROBE_LAST) begin
            cnt_reg <= '0;
            // Fixed mode, or acknowledge already seen: finish the strobe now.
            if (USE_DTACK == 0 || !dtack_s2_reg) begin
              rs_b_reg      <= 1'b1;
              ws_b_reg      <= 1'b1;
              rdata_cap_reg <= rw_reg ? bus.bus_d_in : '0;
              state_reg     <= ST_HOLD;
            end else begin
              state_reg <= ST_WAIT_ACK;
            end
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end

        ST_WAIT_ACK: begin
          if (!dtack_s2_reg) begin
            cnt_reg       <= '0;
            rs_b_reg      <= 1'b1;
            ws_b_reg      <= 1'b1;
            rdata_cap_reg <= rw_reg ? bus.bus_d_in : '0;
            state_reg     <= ST_HOLD;
          end else if (cnt_reg == TIMEOUT_LAST) begin
            // No acknowledge in time: abandon the strobe and report an error.
            cnt_reg     <= '0;
            rs_b_reg    <= 1'b1;
            ws_b_reg    <= 1'b1;
            err_cap_reg <= 1'b1;
            state_reg   <= ST_HOLD;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end

        ST_HOLD: begin
          if (cnt_reg == HOLD_LAST) begin
            cnt_reg       <= '0;
            cs_b_reg      <= 1'b1;
            be_b_reg      <= 4'hF;
            as_reg        <= 1'b0;
            d_oe_reg      <= 1'b0;
            rsp_valid_reg <= 1'b1;
            rsp_rdata_reg <= rdata_cap_reg;
            rsp_err_reg   <= err_cap_reg;
            state_reg     <= ST_RESP;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end

        ST_RESP: begin
          state_reg <= ST_IDLE;
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arm_eim_bus_master.sv
// Bench for arm_eim_bus_master: a fixed-timing instance driven with random
// reads/writes against a memory slave and a scoreboard, plus a DTACK-mode
// instance exercised with directed acknowledge / timeout cases.
module tb_arm_eim_bus_master;

  localparam int AW = 24;
  localparam int DW = 32;
  localparam logic [31:0] ACK_DATA = 32'h13579BDF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  arm_eim_bus_master_if #(.AW(AW), .DW(DW)) fx ();
  arm_eim_bus_master_if #(.AW(AW), .DW(DW)) ak ();

  arm_eim_bus_master #(.AW(AW), .DW(DW), .SETUP(2), .STROBE(4), .HOLD(2),
                       .USE_DTACK(0), .TIMEOUT(255)) u_fix (
    .clk(clk), .rst_n(rst_n), .bus(fx.master));

  arm_eim_bus_master #(.AW(AW), .DW(DW), .SETUP(2), .STROBE(4), .HOLD(2),
                       .USE_DTACK(1), .TIMEOUT(16)) u_ack (
    .clk(clk), .rst_n(rst_n), .bus(ak.master));

  typedef struct {
    logic        rw;
    logic [23:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    logic [31:0] rdata;
    int          due;
  } txn_t;

  txn_t rsp_q[$];
  txn_t bus_q[$];

  logic [31:0] ref_mem [int];
  logic [31:0] slv_mem [int];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Power-on contents of any never-written word.
  function automatic logic [31:0] init_val(input int a);
    return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  function automatic logic [31:0] ref_read(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] slv_read(input int a);
    return slv_mem.exists(a) ? slv_mem[a] : init_val(a);
  endfunction

  // Reference: a write replaces exactly the bytes whose enable is low.
  task automatic ref_write(input int a, input logic [31:0] d, input logic [3:0] be_n);
    logic [31:0] w;
    w = ref_read(a);
    for (int i = 0; i < 4; i++)
      if (!be_n[i]) w[8*i +: 8] = d[8*i +: 8];
    ref_mem[a] = w;
  endtask

  // ---------------- memory slave on the fixed-timing bus ----------------
  always @(negedge clk) begin
    logic [31:0] w;
    if (!fx.bus_cs_b && !fx.bus_ws_b) begin
      w = slv_read(int'(fx.bus_a));
      for (int i = 0; i < 4; i++)
        if (!fx.bus_be_b[i]) w[8*i +: 8] = fx.bus_d_out[8*i +: 8];
      slv_mem[int'(fx.bus_a)] = w;
    end
    fx.bus_d_in = (!fx.bus_cs_b && !fx.bus_rs_b) ? slv_read(int'(fx.bus_a)) : $urandom;
  end

  // Simple data source on the DTACK bus: valid data only while RS_B is low.
  always @(negedge clk) ak.bus_d_in = !ak.bus_rs_b ? ACK_DATA : ~ACK_DATA;

  // ---------------- response monitor (scoreboard) ----------------
  always @(negedge clk) begin
    txn_t t;
    if (rst_n && fx.rsp_valid) begin
      if (rsp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: actual rsp_valid=1 required no response (t=%0t)", $time);
      end else begin
        t = rsp_q.pop_front();
        check("rsp_rdata", 64'(fx.rsp_rdata), 64'(t.rdata));
        check("rsp_err", 64'(fx.rsp_err), 64'd0);
        check("rsp_latency", 64'(cyc), 64'(t.due));
        $display("txn %s a=%06h wd=%08h be_n=%b -> rdata=%08h err=%0d",
                 t.rw ? "RD" : "WR", t.a, t.d, t.be, fx.rsp_rdata, fx.rsp_err);
      end
    end
  end

  // ---------------- bus protocol monitor ----------------
  int   hi_run = 2;
  int   lo_len, stb_start, stb_len;
  bit   in_cyc = 1'b0;
  txn_t bt;

  always @(negedge clk) begin
    logic strobe_b;
    if (!rst_n) begin
      in_cyc = 1'b0;
      hi_run = 2;
    end else if (!fx.bus_cs_b) begin
      if (!in_cyc) begin
        in_cyc = 1'b1; lo_len = 0; stb_start = -1; stb_len = 0;
        check("cs_gap_ge2", 64'(hi_run >= 2), 64'd1);
        check("as_first", 64'(fx.bus_as), 64'd1);
        if (bus_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_cs: actual cs_b=0 required idle bus (t=%0t)", $time);
          bt = '{rw: 1'b1, a: '0, d: '0, be: 4'hF, rdata: '0, due: 0};
        end else begin
          bt = bus_q.pop_front();
        end
      end else begin
        check("as_later", 64'(fx.bus_as), 64'd0);
      end
      check("doe_vs_rs", 64'(fx.bus_d_oe && !fx.bus_rs_b), 64'd0);
      check("bus_a", 64'(fx.bus_a), 64'(bt.a));
      check("bus_be_b", 64'(fx.bus_be_b), 64'(bt.be));
      check("bus_d_oe", 64'(fx.bus_d_oe), 64'(!bt.rw));
      if (!bt.rw) begin
        check("bus_d_out", 64'(fx.bus_d_out), 64'(bt.d));
        check("rs_b_idle_on_wr", 64'(fx.bus_rs_b), 64'd1);
      end else begin
        check("ws_b_idle_on_rd", 64'(fx.bus_ws_b), 64'd1);
      end
      strobe_b = bt.rw ? fx.bus_rs_b : fx.bus_ws_b;
      if (!strobe_b) begin
        if (stb_start < 0) stb_start = lo_len;
        stb_len++;
      end
      lo_len++;
    end else begin
      check("be_b_idle", 64'(fx.bus_be_b), 64'hF);
      check("strobes_idle", 64'({fx.bus_rs_b, fx.bus_ws_b, fx.bus_d_oe}), 64'b110);
      if (in_cyc) begin
        check("cs_low_len", 64'(lo_len), 64'd8);
        check("strobe_start", 64'(stb_start), 64'd2);
        check("strobe_len", 64'(stb_len), 64'd4);
        in_cyc = 1'b0;
        hi_run = 0;
      end
      hi_run++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic rw, input logic [23:0] a, input logic [31:0] d,
                       input logic [3:0] be, input bit expect_rsp);
    txn_t t;
    int   n;
    @(negedge clk);
    fx.cmd_valid = 1'b1; fx.cmd_rw = rw; fx.cmd_addr = a; fx.cmd_wdata = d; fx.cmd_be_n = be;
    n = 0;
    while (!fx.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_wait", 64'(n < 50), 64'd1);
    if (n < 50) begin
      t.rw = rw; t.a = a; t.d = d; t.be = be;
      t.rdata = rw ? ref_read(int'(a)) : 32'h0;
      t.due = cyc + 9;
      if (!rw) ref_write(int'(a), d, be);
      if (expect_rsp) rsp_q.push_back(t);
      bus_q.push_back(t);
      @(negedge clk);
    end
    fx.cmd_valid = 1'b0;
    fx.cmd_wdata = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while (rsp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(rsp_q.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic ack_read(input int drop_at, output int low_cnt, output logic [31:0] rdata,
                          output logic err, output bit ok);
    int n = 0;
    low_cnt = 0; rdata = '0; err = 1'b0; ok = 1'b0;
    @(negedge clk);
    check("ack_cmd_ready", 64'(ak.cmd_ready), 64'd1);
    ak.cmd_valid = 1'b1; ak.cmd_rw = 1'b1; ak.cmd_addr = 24'h000055; ak.cmd_be_n = 4'h0;
    @(negedge clk);
    ak.cmd_valid = 1'b0;
    while (n < 200) begin
      if (!ak.bus_rs_b) begin
        if (low_cnt == drop_at) ak.bus_dtack_b = 1'b0;
        low_cnt++;
      end
      if (ak.rsp_valid) begin
        rdata = ak.rsp_rdata; err = ak.rsp_err; ok = 1'b1;
        break;
      end
      @(negedge clk);
      n++;
    end
    check("ack_rsp_seen", 64'(ok), 64'd1);
    $display("txn ACK-RD drop_at=%0d strobe_low=%0d rdata=%08h err=%0d", drop_at, low_cnt, rdata, err);
  endtask

  initial begin
    int          low;
    logic [31:0] rd;
    logic        er;
    bit          ok;
    logic [23:0] pool [8];
    int          n;

    fx.cmd_valid = 0; fx.cmd_rw = 0; fx.cmd_addr = '0; fx.cmd_wdata = '0; fx.cmd_be_n = 4'hF;
    fx.bus_dtack_b = 1'b1; fx.bus_d_in = '0;
    ak.cmd_valid = 0; ak.cmd_rw = 0; ak.cmd_addr = '0; ak.cmd_wdata = '0; ak.cmd_be_n = 4'hF;
    ak.bus_dtack_b = 1'b1; ak.bus_d_in = '0;
    ref_mem[4] = 32'h12345678;
    slv_mem[4] = 32'h12345678;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_cs_b", 64'(fx.bus_cs_b), 64'd1);
    check("rst_rs_ws", 64'({fx.bus_rs_b, fx.bus_ws_b}), 64'b11);
    check("rst_be_b", 64'(fx.bus_be_b), 64'hF);
    check("rst_as_doe", 64'({fx.bus_as, fx.bus_d_oe}), 64'b00);
    check("rst_a_dout", 64'({fx.bus_a, fx.bus_d_out}), 64'd0);
    check("rst_rsp", 64'({fx.rsp_valid, fx.rsp_err, fx.rsp_rdata}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 64'(fx.cmd_ready), 64'd1);

    // Directed: full write, preset read, partial-byte write then read-back
    issue(1'b0, 24'h000010, 32'hDEADBEEF, 4'b0000, 1'b1);
    issue(1'b1, 24'h000004, 32'h0, 4'b0000, 1'b1);
    issue(1'b0, 24'h000030, 32'hA1B2C3D4, 4'b1100, 1'b1);
    issue(1'b1, 24'h000030, 32'h0, 4'b0000, 1'b1);
    issue(1'b1, 24'h000010, 32'h0, 4'b0000, 1'b1);
    drain();

    // Random traffic over a small address pool so reads hit earlier writes
    for (int i = 0; i < 8; i++) pool[i] = 24'($urandom);
    for (int i = 0; i < 40; i++) begin
      logic [23:0] a;
      a = ($urandom_range(0, 4) == 0) ? 24'($urandom) : pool[$urandom_range(0, 7)];
      issue(($urandom_range(0, 9) < 4), a, $urandom, 4'($urandom), 1'b1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain();

    // DTACK mode: ack arriving 10 cycles into the strobe
    ack_read(10, low, rd, er, ok);
    check("ack_strobe_len_min", 64'(low >= 12), 64'd1);
    check("ack_strobe_len_max", 64'(low <= 14), 64'd1);
    check("ack_rdata", 64'(rd), 64'(ACK_DATA));
    check("ack_err", 64'(er), 64'd0);
    ak.bus_dtack_b = 1'b1;
    repeat (4) @(negedge clk);

    // DTACK mode: no ack at all -> timeout after STROBE+16 cycles
    ack_read(-1, low, rd, er, ok);
    check("to_strobe_len", 64'(low), 64'd20);
    check("to_rdata", 64'(rd), 64'd0);
    check("to_err", 64'(er), 64'd1);
    repeat (2) @(negedge clk);

    // DTACK mode: ack already low before the strobe ends -> no extension
    ak.bus_dtack_b = 1'b0;
    repeat (3) @(negedge clk);
    ack_read(-1, low, rd, er, ok);
    check("early_strobe_len", 64'(low), 64'd4);
    check("early_rdata", 64'(rd), 64'(ACK_DATA));
    check("early_err", 64'(er), 64'd0);
    ak.bus_dtack_b = 1'b1;
    repeat (4) @(negedge clk);

    // Reset while the write strobe is low: bus released at once, no response
    issue(1'b0, 24'h0000F0, 32'h55AA55AA, 4'b0000, 1'b0);
    n = 0;
    while (fx.bus_ws_b && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ws_seen_before_rst", 64'(fx.bus_ws_b), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_strobes", 64'({fx.bus_cs_b, fx.bus_rs_b, fx.bus_ws_b}), 64'b111);
    check("arst_doe_as", 64'({fx.bus_d_oe, fx.bus_as}), 64'b00);
    check("arst_be_b", 64'(fx.bus_be_b), 64'hF);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_abort", 64'(fx.cmd_ready), 64'd1);
    for (int i = 0; i < 15; i++) begin
      check("no_rsp_after_abort", 64'(fx.rsp_valid), 64'd0);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout: actual simulation still running required finished");
    $fatal(1, "timeout");
  end

endmodule
